// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 3:1 mux.
// Grant latency 1 clock; tenure capped at MAX_HOLD cycles; one idle cycle between grants.
module mux3_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t           r_state;
    logic [2:0]       r_gnt;
    logic [1:0]       r_sel;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [2:0]       w_gnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic [1:0]       w_last_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_timeout_nxt;
    logic [1:0]       w_win;

    // Search starts just after the previous owner, so it ends up lowest priority.
    always_comb begin
        w_win = 2'd0;
        unique case (r_last)
            2'd0:    w_win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_sel_nxt     = r_sel;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_OWN;
                    w_gnt_nxt   = 3'b001 << w_win;
                    w_sel_nxt   = w_win;
                    w_last_nxt  = w_win;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            default: begin
                if (!req[r_sel] || (r_cnt == CNT_W'(MAX_HOLD))) begin
                    w_state_nxt   = S_IDLE;
                    w_gnt_nxt     = 3'b000;
                    w_sel_nxt     = 2'd0;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = req[r_sel];
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= 3'b000;
            r_sel     <= 2'd0;
            r_last    <= 2'd2;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_sel     <= w_sel_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign busy    = |r_gnt;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed bench for mux3_rr_arbiter: a vector table on MAX_HOLD=8 plus
// hand-written tenure, fairness, MAX_HOLD=1 and async-reset sequences.
module tb_mux3_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;

    logic [2:0] gnt8, gnt4, gnt3, gnt1;
    logic [1:0] sel8, sel4, sel3, sel1;
    logic       busy8, busy4, busy3, busy1;
    logic       to8, to4, to3, to1;
    logic [2:0] pg8 = 3'b000, pg4 = 3'b000, pg3 = 3'b000, pg1 = 3'b000;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux3_rr_arbiter #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .req(req), .gnt(gnt8), .sel(sel8), .busy(busy8), .timeout(to8));
    mux3_rr_arbiter #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .req(req), .gnt(gnt4), .sel(sel4), .busy(busy4), .timeout(to4));
    mux3_rr_arbiter #(.MAX_HOLD(3)) dut3 (.clk(clk), .rst(rst), .req(req), .gnt(gnt3), .sel(sel3), .busy(busy3), .timeout(to3));
    mux3_rr_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .req(req), .gnt(gnt1), .sel(sel1), .busy(busy1), .timeout(to1));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] enc(input logic [2:0] g);
        return (g == 3'b010) ? 2'd1 : ((g == 3'b100) ? 2'd2 : 2'd0);
    endfunction

    task automatic inv(input string name, input logic [2:0] g, input logic [1:0] s,
                       input logic b, input logic t, input logic [2:0] pg);
        chk({name, "_onehot"}, 8'($onehot0(g)), 8'd1);
        chk({name, "_sel_enc"}, 8'(s), 8'(enc(g)));
        chk({name, "_busy"}, 8'(b), 8'(|g));
        if (t)
            chk({name, "_to_after_own"}, 8'((pg != 3'b000) && (g == 3'b000)), 8'd1);
    endtask

    always @(negedge clk) begin
        inv("d8", gnt8, sel8, busy8, to8, pg8);
        inv("d4", gnt4, sel4, busy4, to4, pg4);
        inv("d3", gnt3, sel3, busy3, to3, pg3);
        inv("d1", gnt1, sel1, busy1, to1, pg1);
        pg8 = gnt8;
        pg4 = gnt4;
        pg3 = gnt3;
        pg1 = gnt1;
    end

    typedef struct {
        logic       r;
        logic [2:0] rq;
        logic [2:0] g;
        logic [1:0] s;
        logic       b;
        logic       t;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] g,
                                input logic [1:0] s, input logic b, input logic t);
        vec_t v;
        v.r = r; v.rq = rq; v.g = g; v.s = s; v.b = b; v.t = t;
        return v;
    endfunction

    localparam int NV = 25;
    vec_t tbl [NV];

    initial begin
        // Post-reset single request, then drop.
        tbl[0]  = mk(1, 3'b000, 3'b000, 2'd0, 0, 0);
        tbl[1]  = mk(0, 3'b001, 3'b001, 2'd0, 1, 0);
        tbl[2]  = mk(0, 3'b001, 3'b001, 2'd0, 1, 0);
        tbl[3]  = mk(0, 3'b001, 3'b001, 2'd0, 1, 0);
        tbl[4]  = mk(0, 3'b000, 3'b000, 2'd0, 0, 0);
        tbl[5]  = mk(0, 3'b000, 3'b000, 2'd0, 0, 0);
        // Rotation with each owner dropping after two cycles.
        tbl[6]  = mk(1, 3'b000, 3'b000, 2'd0, 0, 0);
        tbl[7]  = mk(0, 3'b111, 3'b001, 2'd0, 1, 0);
        tbl[8]  = mk(0, 3'b111, 3'b001, 2'd0, 1, 0);
        tbl[9]  = mk(0, 3'b110, 3'b000, 2'd0, 0, 0);
        tbl[10] = mk(0, 3'b111, 3'b010, 2'd1, 1, 0);
        tbl[11] = mk(0, 3'b111, 3'b010, 2'd1, 1, 0);
        tbl[12] = mk(0, 3'b101, 3'b000, 2'd0, 0, 0);
        tbl[13] = mk(0, 3'b111, 3'b100, 2'd2, 1, 0);
        tbl[14] = mk(0, 3'b111, 3'b100, 2'd2, 1, 0);
        tbl[15] = mk(0, 3'b011, 3'b000, 2'd0, 0, 0);
        tbl[16] = mk(0, 3'b111, 3'b001, 2'd0, 1, 0);
        tbl[17] = mk(0, 3'b111, 3'b001, 2'd0, 1, 0);
        tbl[18] = mk(0, 3'b000, 3'b000, 2'd0, 0, 0);
        // Owner 0 holding while requester 2 pulses for one cycle.
        tbl[19] = mk(0, 3'b001, 3'b001, 2'd0, 1, 0);
        tbl[20] = mk(0, 3'b101, 3'b001, 2'd0, 1, 0);
        tbl[21] = mk(0, 3'b001, 3'b001, 2'd0, 1, 0);
        tbl[22] = mk(0, 3'b001, 3'b001, 2'd0, 1, 0);
        tbl[23] = mk(0, 3'b000, 3'b000, 2'd0, 0, 0);
        tbl[24] = mk(0, 3'b000, 3'b000, 2'd0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].r;
            req = tbl[i].rq;
            tick;
            chk($sformatf("v%0d_gnt", i), 8'(gnt8), 8'(tbl[i].g));
            chk($sformatf("v%0d_sel", i), 8'(sel8), 8'(tbl[i].s));
            chk($sformatf("v%0d_busy", i), 8'(busy8), 8'(tbl[i].b));
            chk($sformatf("v%0d_to", i), 8'(to8), 8'(tbl[i].t));
        end

        // Tenure limit 4 with requester 1 held.
        rst = 1'b1; req = 3'b000; tick;
        rst = 1'b0; req = 3'b010;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk($sformatf("tmo4_c%0d_gnt", i), 8'(gnt4), (i % 5 < 4) ? 8'h02 : 8'h00);
            chk($sformatf("tmo4_c%0d_to", i), 8'(to4), (i % 5 < 4) ? 8'h00 : 8'h01);
        end

        // Tenure limit 3 with requesters 0 and 1 held: grants alternate.
        rst = 1'b1; req = 3'b000; tick;
        rst = 1'b0; req = 3'b011;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (i % 4 < 3) begin
                chk($sformatf("fair_c%0d_gnt", i), 8'(gnt3), ((i / 4) % 2 == 0) ? 8'h01 : 8'h02);
                chk($sformatf("fair_c%0d_sel", i), 8'(sel3), ((i / 4) % 2 == 0) ? 8'h00 : 8'h01);
                chk($sformatf("fair_c%0d_to", i), 8'(to3), 8'h00);
            end else begin
                chk($sformatf("fair_c%0d_gnt", i), 8'(gnt3), 8'h00);
                chk($sformatf("fair_c%0d_to", i), 8'(to3), 8'h01);
            end
        end

        // Tenure limit 1: every grant is a single cycle.
        rst = 1'b1; req = 3'b000; tick;
        rst = 1'b0; req = 3'b001;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk($sformatf("h1_c%0d_gnt", i), 8'(gnt1), (i % 2 == 0) ? 8'h01 : 8'h00);
            chk($sformatf("h1_c%0d_to", i), 8'(to1), (i % 2 == 0) ? 8'h00 : 8'h01);
        end
        req = 3'b100; tick;
        chk("h1_pulse_gnt", 8'(gnt1), 8'h04);
        req = 3'b000; tick;
        chk("h1_drop_gnt", 8'(gnt1), 8'h00);
        chk("h1_drop_to", 8'(to1), 8'h00);

        // Async reset in the middle of a grant to requester 2.
        rst = 1'b1; req = 3'b000; tick;
        rst = 1'b0; req = 3'b100;
        tick;
        chk("ar_pre_gnt", 8'(gnt8), 8'h04);
        chk("ar_pre_sel", 8'(sel8), 8'h02);
        tick;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_async_gnt", 8'(gnt8), 8'h00);
        chk("ar_async_sel", 8'(sel8), 8'h00);
        chk("ar_async_busy", 8'(busy8), 8'h00);
        req = 3'b101;
        tick;
        rst = 1'b0;
        #1;
        chk("ar_rel_busy", 8'(busy8), 8'h00);
        chk("ar_rel_sel", 8'(sel8), 8'h00);
        tick;
        chk("ar_first_gnt", 8'(gnt8), 8'h01);
        chk("ar_first_sel", 8'(sel8), 8'h00);
        req = 3'b000;
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
